// File: rtl/calc2_req_scheduler.sv
// calc2_req_scheduler: shares one CALC2 execution pipe among four requester
// ports (a..d = 0..3).
//  - Each port owns one request slot (calc2_req_slot) that captures a
//    two-cycle request: cmd/tag/op1 in the first cycle, op2 in the second.
//  - A round-robin arbiter issues ready slots to the pipe. The issue register
//    is loaded from slots that are entering PEND as well as slots already in
//    PEND, so the earliest issue is two cycles after the cmd cycle.
//  - Pipe completions, and local errors for invalid or duplicate-tag
//    requests, are returned on the owning port as a one-cycle pulse.
// Ports:
//  c_clk, reset                  clock, synchronous active-high reset
//  req_cmd/req_data/req_tag      per-port request inputs (packed, port 0 = LSBs)
//  port_ready                    per-port: slot idle, a new cmd may be sent
//  iss_valid/iss_ready/iss_*     issue handshake to the shared pipe
//  cpl_*                         completion strobe from the pipe
//  out_resp/out_data/out_tag     per-port response (0 = no response)
//  drop_err                      sticky protocol/completion error flag

// One request slot per port: IDLE -> OP2 -> PEND -> IDLE, or OP2 -> ERR -> IDLE.
module calc2_req_slot #(
    parameter int DW = 32,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic [DW-1:0] data,
    input  logic [TW-1:0] tag,
    input  logic          dup,        // latched tag is already in flight
    input  logic          grant,      // issue transfer of this slot
    input  logic          err_ack,    // error response emitted this cycle
    output logic          ready,
    output logic          pend,
    output logic          going_pend, // OP2 and request is good
    output logic          err,
    output logic          cmd_drop,   // cmd presented while busy
    output logic [3:0]    s_cmd,
    output logic [DW-1:0] s_op1,
    output logic [DW-1:0] op2_next,   // op2 as it will be in PEND
    output logic [TW-1:0] s_tag
);
    typedef enum logic [1:0] {IDLE, OP2, PEND, ERR} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] s_op2;
    logic          cmd_ok;

    assign cmd_ok = (s_cmd == 4'd1) || (s_cmd == 4'd2) ||
                    (s_cmd == 4'd5) || (s_cmd == 4'd6);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        going_pend = 1'b0;
        case (state)
            IDLE: if (cmd != 4'd0) state_nxt = OP2;
            OP2: begin
                // dup is the pre-clear inflight view: a completion in this
                // very cycle still counts as a duplicate.
                if (cmd_ok && !dup) begin
                    state_nxt  = PEND;
                    going_pend = 1'b1;
                end else begin
                    state_nxt  = ERR;
                end
            end
            PEND: if (grant)   state_nxt = IDLE;
            ERR:  if (err_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_cmd <= '0;
            s_tag <= '0;
            s_op1 <= '0;
            s_op2 <= '0;
        end else begin
            if (state == IDLE && cmd != 4'd0) begin
                s_cmd <= cmd;
                s_tag <= tag;
                s_op1 <= data;
            end
            // op2 is consumed even when the cmd turns out invalid
            if (state == OP2) s_op2 <= data;
        end
    end

    assign op2_next = (state == OP2) ? data : s_op2;
    assign ready    = (state == IDLE);
    assign pend     = (state == PEND);
    assign err      = (state == ERR);
    assign cmd_drop = (cmd != 4'd0) && (state != IDLE);
endmodule

module calc2_req_scheduler #(
    parameter int DW    = 32,
    parameter int NPORT = 4,
    parameter int TW    = 2
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic [4*NPORT-1:0]  req_cmd,
    input  logic [DW*NPORT-1:0] req_data,
    input  logic [TW*NPORT-1:0] req_tag,
    output logic [NPORT-1:0]    port_ready,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [3:0]          iss_cmd,
    output logic [DW-1:0]       iss_op1,
    output logic [DW-1:0]       iss_op2,
    output logic [1:0]          iss_port,
    output logic [TW-1:0]       iss_tag,
    input  logic                cpl_valid,
    input  logic [1:0]          cpl_port,
    input  logic [TW-1:0]       cpl_tag,
    input  logic [1:0]          cpl_resp,
    input  logic [DW-1:0]       cpl_data,
    output logic [2*NPORT-1:0]  out_resp,
    output logic [DW*NPORT-1:0] out_data,
    output logic [TW*NPORT-1:0] out_tag,
    output logic                drop_err
);
    localparam int NTAG = 1 << TW;

    logic [NPORT-1:0]           pend, going_pend, err, cmd_drop, dup;
    logic [NPORT-1:0]           grant, err_ack, cand, hit_port;
    logic [NPORT-1:0][3:0]      s_cmd;
    logic [NPORT-1:0][DW-1:0]   s_op1, op2_next;
    logic [NPORT-1:0][TW-1:0]   s_tag;
    logic [NPORT-1:0][NTAG-1:0] inflight;
    logic [NPORT-1:0][1:0]      out_resp_r;
    logic [NPORT-1:0][DW-1:0]   out_data_r;
    logic [NPORT-1:0][TW-1:0]   out_tag_r;
    logic [1:0]                 rr, ptr_eff, pick, idx;
    logic                       found, xfer, cpl_hit;

    assign xfer    = iss_valid && iss_ready;
    assign cpl_hit = cpl_valid && inflight[cpl_port][cpl_tag];

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        calc2_req_slot #(.DW(DW), .TW(TW)) u_slot (
            .clk        (c_clk),
            .reset      (reset),
            .cmd        (req_cmd[4*i +: 4]),
            .data       (req_data[DW*i +: DW]),
            .tag        (req_tag[TW*i +: TW]),
            .dup        (dup[i]),
            .grant      (grant[i]),
            .err_ack    (err_ack[i]),
            .ready      (port_ready[i]),
            .pend       (pend[i]),
            .going_pend (going_pend[i]),
            .err        (err[i]),
            .cmd_drop   (cmd_drop[i]),
            .s_cmd      (s_cmd[i]),
            .s_op1      (s_op1[i]),
            .op2_next   (op2_next[i]),
            .s_tag      (s_tag[i])
        );
        assign dup[i]      = inflight[i][s_tag[i]];
        assign grant[i]    = xfer && (iss_port == 2'(i));
        assign hit_port[i] = cpl_hit && (cpl_port == 2'(i));
        // completion has priority; the error response waits
        assign err_ack[i]  = err[i] && !hit_port[i];
        // the slot already sitting in the issue register is not a candidate
        assign cand[i]     = going_pend[i] ||
                             (pend[i] && !(iss_valid && iss_port == 2'(i)));
    end

    // Round-robin pick; on a transfer cycle the search already starts after
    // the port being transferred so back-to-back issues rotate correctly.
    always_comb begin
        ptr_eff = xfer ? iss_port + 2'd1 : rr;
        found   = 1'b0;
        pick    = ptr_eff;
        idx     = ptr_eff;
        for (int k = 0; k < NPORT; k++) begin
            idx = ptr_eff + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            rr        <= '0;
            iss_valid <= 1'b0;
            iss_cmd   <= '0;
            iss_op1   <= '0;
            iss_op2   <= '0;
            iss_port  <= '0;
            iss_tag   <= '0;
        end else begin
            if (xfer) rr <= iss_port + 2'd1;
            // hold the grant stable until it transfers
            if (!iss_valid || iss_ready) begin
                iss_valid <= found;
                iss_cmd   <= found ? s_cmd[pick]    : '0;
                iss_op1   <= found ? s_op1[pick]    : '0;
                iss_op2   <= found ? op2_next[pick] : '0;
                iss_port  <= found ? pick           : '0;
                iss_tag   <= found ? s_tag[pick]    : '0;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            out_resp_r <= '0;
            out_data_r <= '0;
            out_tag_r  <= '0;
            inflight   <= '0;
            drop_err   <= 1'b0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (hit_port[p]) begin
                    out_resp_r[p] <= cpl_resp;
                    out_data_r[p] <= cpl_data;
                    out_tag_r[p]  <= cpl_tag;
                end else if (err[p]) begin
                    out_resp_r[p] <= 2'd2;
                    out_data_r[p] <= '0;
                    out_tag_r[p]  <= s_tag[p];
                end else begin
                    out_resp_r[p] <= '0;
                    out_data_r[p] <= '0;
                    out_tag_r[p]  <= '0;
                end
            end
            if (cpl_hit) inflight[cpl_port][cpl_tag] <= 1'b0;
            if (xfer)    inflight[iss_port][iss_tag] <= 1'b1;
            if ((cpl_valid && !cpl_hit) || (|cmd_drop)) drop_err <= 1'b1;
        end
    end

    assign out_resp = out_resp_r;
    assign out_data = out_data_r;
    assign out_tag  = out_tag_r;
endmodule

// File: tb/tb_calc2_req_scheduler.sv
// Directed bench for calc2_req_scheduler. Inputs change 1 time unit after
// the rising edge; outputs are sampled at that point too.
module tb_calc2_req_scheduler;
    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0]  req_cmd = '0;
    logic [127:0] req_data = '0;
    logic [7:0]   req_tag = '0;
    logic [3:0]   port_ready;
    logic         iss_valid;
    logic         iss_ready = 1'b0;
    logic [3:0]   iss_cmd;
    logic [31:0]  iss_op1, iss_op2;
    logic [1:0]   iss_port, iss_tag;
    logic         cpl_valid = 1'b0;
    logic [1:0]   cpl_port = '0, cpl_tag = '0, cpl_resp = '0;
    logic [31:0]  cpl_data = '0;
    logic [7:0]   out_resp, out_tag;
    logic [127:0] out_data;
    logic         drop_err;

    int n_chk = 0;
    int n_bad = 0;

    calc2_req_scheduler dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd(req_cmd), .req_data(req_data), .req_tag(req_tag),
        .port_ready(port_ready),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_cmd(iss_cmd),
        .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_port(iss_port), .iss_tag(iss_tag),
        .cpl_valid(cpl_valid), .cpl_port(cpl_port), .cpl_tag(cpl_tag),
        .cpl_resp(cpl_resp), .cpl_data(cpl_data),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .drop_err(drop_err)
    );

    always #5 c_clk = ~c_clk;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [3:0] c, input logic [1:0] t,
                           input logic [31:0] d);
        req_cmd[4*p +: 4]   = c;
        req_tag[2*p +: 2]   = t;
        req_data[32*p +: 32] = d;
    endtask

    task automatic cpl(input logic [1:0] p, input logic [1:0] t,
                       input logic [1:0] r, input logic [31:0] d);
        cpl_valid = 1'b1; cpl_port = p; cpl_tag = t; cpl_resp = r; cpl_data = d;
    endtask

    task automatic cpl_off();
        cpl_valid = 1'b0; cpl_port = '0; cpl_tag = '0; cpl_resp = '0; cpl_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic chk_iss(input string nm, input logic [1:0] p, input logic [3:0] c,
                           input logic [1:0] t, input logic [31:0] o1, input logic [31:0] o2);
        chk({nm, "_vld"},  64'(iss_valid), 64'd1);
        chk({nm, "_port"}, 64'(iss_port), 64'(p));
        chk({nm, "_cmd"},  64'(iss_cmd), 64'(c));
        chk({nm, "_tag"},  64'(iss_tag), 64'(t));
        chk({nm, "_op1"},  64'(iss_op1), 64'(o1));
        chk({nm, "_op2"},  64'(iss_op2), 64'(o2));
    endtask

    task automatic chk_out(input string nm, input int p, input logic [1:0] r,
                           input logic [31:0] d, input logic [1:0] t);
        chk({nm, "_resp"}, 64'(out_resp[2*p +: 2]), 64'(r));
        chk({nm, "_data"}, 64'(out_data[32*p +: 32]), 64'(d));
        chk({nm, "_tag"},  64'(out_tag[2*p +: 2]), 64'(t));
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_ready", 64'(port_ready), 64'hF);
        chk("rst_iss",   64'(iss_valid), 64'd0);
        chk("rst_resp",  64'(out_resp), 64'd0);
        chk("rst_drop",  64'(drop_err), 64'd0);

        // 1: single add on port a
        iss_ready = 1'b1;
        set_req(0, 4'd1, 2'd0, 32'd5);
        tick();
        set_req(0, 4'd0, 2'd0, 32'd3);
        chk("t1_busy", 64'(port_ready), 64'hE);
        tick();
        set_req(0, 4'd0, 2'd0, 32'd0);
        chk_iss("t1_iss", 2'd0, 4'd1, 2'd0, 32'd5, 32'd3);
        tick();
        chk("t1_idle", 64'(iss_valid), 64'd0);
        chk("t1_rdy",  64'(port_ready), 64'hF);
        cpl(2'd0, 2'd0, 2'd1, 32'd8);
        tick();
        cpl_off();
        chk_out("t1_out", 0, 2'd1, 32'd8, 2'd0);
        tick();
        chk("t1_pulse", 64'(out_resp), 64'd0);

        // 2: all four ports at once, then b and d
        do_reset();
        for (int p = 0; p < 4; p++) set_req(p, 4'd1, 2'd1, 32'(10 + p));
        tick();
        for (int p = 0; p < 4; p++) set_req(p, 4'd0, 2'd0, 32'(100 + p));
        tick();
        req_data = '0;
        for (int p = 0; p < 4; p++) begin
            chk_iss($sformatf("t2_iss%0d", p), 2'(p), 4'd1, 2'd1, 32'(10 + p), 32'(100 + p));
            tick();
        end
        chk("t2_done", 64'(iss_valid), 64'd0);
        cpl(2'd2, 2'd1, 2'd2, 32'h55);
        tick();
        cpl_off();
        chk_out("t2_cplc", 2, 2'd2, 32'h55, 2'd1);
        chk("t2_cpla", 64'(out_resp[1:0]), 64'd0);
        set_req(1, 4'd1, 2'd2, 32'd20);
        set_req(3, 4'd1, 2'd2, 32'd30);
        tick();
        set_req(1, 4'd0, 2'd0, 32'd21);
        set_req(3, 4'd0, 2'd0, 32'd31);
        tick();
        req_data = '0;
        chk_iss("t2_b", 2'd1, 4'd1, 2'd2, 32'd20, 32'd21);
        tick();
        chk_iss("t2_d", 2'd3, 4'd1, 2'd2, 32'd30, 32'd31);
        tick();

        // 3: invalid cmd on port c
        set_req(2, 4'd3, 2'd2, 32'd1);
        tick();
        set_req(2, 4'd0, 2'd0, 32'd2);
        tick();
        req_data = '0;
        chk("t3_noiss", 64'(iss_valid), 64'd0);
        tick();
        chk_out("t3_err", 2, 2'd2, 32'd0, 2'd2);
        chk("t3_noiss2", 64'(iss_valid), 64'd0);
        chk("t3_rdy", 64'(port_ready), 64'hF);

        // 4: duplicate tag on port a (tag 1 still in flight from test 2)
        set_req(0, 4'd2, 2'd1, 32'd9);
        tick();
        set_req(0, 4'd0, 2'd0, 32'd9);
        tick();
        req_data = '0;
        chk("t4_noiss", 64'(iss_valid), 64'd0);
        tick();
        chk_out("t4_dup", 0, 2'd2, 32'd0, 2'd1);
        cpl(2'd0, 2'd1, 2'd1, 32'd7);
        tick();
        cpl_off();
        chk_out("t4_cpl", 0, 2'd1, 32'd7, 2'd1);
        set_req(0, 4'd2, 2'd1, 32'd50);
        tick();
        set_req(0, 4'd0, 2'd0, 32'd8);
        tick();
        req_data = '0;
        chk_iss("t4_iss", 2'd0, 4'd2, 2'd1, 32'd50, 32'd8);
        tick();

        // 5: pipe stalled with a and b pending
        do_reset();
        iss_ready = 1'b0;
        set_req(0, 4'd5, 2'd3, 32'd40);
        set_req(1, 4'd6, 2'd3, 32'd41);
        tick();
        set_req(0, 4'd0, 2'd0, 32'd1);
        set_req(1, 4'd0, 2'd0, 32'd2);
        tick();
        req_data = '0;
        for (int s = 0; s < 5; s++) begin
            chk_iss($sformatf("t5_hold%0d", s), 2'd0, 4'd5, 2'd3, 32'd40, 32'd1);
            tick();
        end
        iss_ready = 1'b1;
        chk_iss("t5_xfer", 2'd0, 4'd5, 2'd3, 32'd40, 32'd1);
        tick();
        chk_iss("t5_b", 2'd1, 4'd6, 2'd3, 32'd41, 32'd2);

        // 6: reset with c pending in the issue register, d in OP2, a/b in flight
        set_req(2, 4'd1, 2'd0, 32'd60);
        tick();
        iss_ready = 1'b0;
        set_req(2, 4'd0, 2'd0, 32'd61);
        set_req(3, 4'd1, 2'd0, 32'd70);
        tick();
        set_req(2, 4'd0, 2'd0, 32'd0);
        set_req(3, 4'd0, 2'd0, 32'd71);
        chk("t6_pre", 64'(port_ready), 64'h3);
        reset = 1'b1;
        cpl(2'd1, 2'd3, 2'd1, 32'd99);
        tick();
        reset = 1'b0;
        req_data = '0;
        chk("t6_rdy",  64'(port_ready), 64'hF);
        chk("t6_iss",  64'(iss_valid), 64'd0);
        chk("t6_resp", 64'(out_resp), 64'd0);
        chk("t6_data", 64'(out_data), 64'd0);
        chk("t6_drop0", 64'(drop_err), 64'd0);
        cpl(2'd0, 2'd3, 2'd1, 32'd1);
        tick();
        cpl_off();
        chk("t6_late", 64'(out_resp), 64'd0);
        chk("t6_drop1", 64'(drop_err), 64'd1);
        tick(); tick();
        chk("t6_sticky", 64'(drop_err), 64'd1);
        chk("t6_idle", 64'(iss_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
